// File: rtl/wishbone_mem_responder.sv
// Wishbone slave terminating one interconnect port with a word-addressed byte-writable RAM.
// Serves one request at a time with a fixed number of wait states before a single-cycle ack.
module wishbone_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wbs_we,
  input  logic        i_wbs_cyc,
  input  logic        i_wbs_stb,
  input  logic [3:0]  i_wbs_sel,
  input  logic [31:0] i_wbs_adr,
  input  logic [31:0] i_wbs_dat,
  output logic [31:0] o_wbs_dat,
  output logic        o_wbs_ack,
  output logic        o_wbs_int
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck, StHold} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q;
  logic [3:0]              sel_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic                    oor_q;
  logic [31:0]             wdat_q;
  logic [31:0]             dat_q;
  logic                    ack_q;
  logic                    int_q;

  logic [31:0]             mem [DEPTH];

  logic                    req;
  logic                    in_range;
  logic                    enter_ack;
  logic                    x_we;
  logic [3:0]              x_sel;
  logic [ADDR_WIDTH-1:0]   x_idx;
  logic                    x_oor;
  logic [31:0]             x_wdat;

  assign req      = (state_q == StIdle) && i_wbs_cyc && i_wbs_stb;
  assign in_range = (i_wbs_adr[31:ADDR_WIDTH] == '0);

  // With zero wait states the access completes on the accepting edge, so use the live inputs.
  always_comb begin
    if (state_q == StIdle) begin
      x_we   = i_wbs_we;
      x_sel  = i_wbs_sel;
      x_idx  = i_wbs_adr[ADDR_WIDTH-1:0];
      x_oor  = !in_range;
      x_wdat = i_wbs_dat;
    end else begin
      x_we   = we_q;
      x_sel  = sel_q;
      x_idx  = idx_q;
      x_oor  = oor_q;
      x_wdat = wdat_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      StWait: begin
        if (!(i_wbs_cyc && i_wbs_stb)) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck: begin
        state_d = StHold;
      end
      StHold: begin
        if (!i_wbs_cyc || !i_wbs_stb) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign enter_ack = (state_d == StAck);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      wdat_q  <= 32'd0;
      dat_q   <= 32'd0;
      ack_q   <= 1'b0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req) begin
        we_q   <= i_wbs_we;
        sel_q  <= i_wbs_sel;
        idx_q  <= i_wbs_adr[ADDR_WIDTH-1:0];
        oor_q  <= !in_range;
        wdat_q <= i_wbs_dat;
      end
      ack_q <= enter_ack;
      int_q <= enter_ack && x_oor;
      dat_q <= (enter_ack && !x_we && !x_oor) ? mem[x_idx] : 32'd0;
    end
  end

  // RAM is never cleared; rst gates the write so a request seen during reset cannot commit.
  always_ff @(posedge clk) begin
    if (rst && enter_ack && x_we && !x_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (x_sel[b]) begin
          mem[x_idx][8*b +: 8] <= x_wdat[8*b +: 8];
        end
      end
    end
  end

  assign o_wbs_dat = dat_q;
  assign o_wbs_ack = ack_q;
  assign o_wbs_int = int_q;

endmodule

// File: tb/tb_wishbone_mem_responder.sv
// Self-checking bench: three responders (1, 3 and 0 wait states) driven one at a time,
// checked against a byte-granular memory model with known-byte tracking.
module tb_wishbone_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [2:0]  cyc;
  logic [2:0]  stb;
  logic [2:0]  ack;
  logic [2:0]  irq;
  logic [31:0] rdat [3];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mdl [3][1024];
  logic [3:0]  kb  [3][1024];

  always #5 clk = ~clk;

  wishbone_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .i_wbs_we(we), .i_wbs_cyc(cyc[0]), .i_wbs_stb(stb[0]),
    .i_wbs_sel(sel), .i_wbs_adr(adr), .i_wbs_dat(wdat),
    .o_wbs_dat(rdat[0]), .o_wbs_ack(ack[0]), .o_wbs_int(irq[0])
  );
  wishbone_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .i_wbs_we(we), .i_wbs_cyc(cyc[1]), .i_wbs_stb(stb[1]),
    .i_wbs_sel(sel), .i_wbs_adr(adr), .i_wbs_dat(wdat),
    .o_wbs_dat(rdat[1]), .o_wbs_ack(ack[1]), .o_wbs_int(irq[1])
  );
  wishbone_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .i_wbs_we(we), .i_wbs_cyc(cyc[2]), .i_wbs_stb(stb[2]),
    .i_wbs_sel(sel), .i_wbs_adr(adr), .i_wbs_dat(wdat),
    .o_wbs_dat(rdat[2]), .o_wbs_ack(ack[2]), .o_wbs_int(irq[2])
  );

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'd0;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  // One full transfer on responder k; stb is held for hold extra cycles after the ack.
  task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input int hold, output logic [31:0] rd);
    int          ws, lat, acks;
    bit          oor;
    logic [31:0] gd, km, m;
    logic        gi;
    ws  = (k == 0) ? 1 : (k == 1) ? 3 : 0;
    oor = (a >= 32'd1024);
    gd  = 32'hx;
    gi  = 1'bx;
    lat = 0;
    @(negedge clk);
    we = w; adr = a; sel = s; wdat = d; cyc[k] = 1'b1; stb[k] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (ack[k]) begin
        lat = c; gd = rdat[k]; gi = irq[k];
        break;
      end
      @(posedge clk);
    end
    n_tests++;
    if (lat !== ws + 1) begin
      n_fail++;
      $display("FAIL latency k=%0d adr=%h: got %0d cycles, want %0d", k, a, lat, ws + 1);
    end
    n_tests++;
    if (gi !== oor) begin
      n_fail++;
      $display("FAIL int k=%0d adr=%h: got %b, want %b", k, a, gi, oor);
    end
    if (!w) begin
      km = oor ? 32'hFFFF_FFFF : lane_mask(kb[k][a[9:0]]);
      m  = oor ? 32'd0 : mdl[k][a[9:0]];
      n_tests++;
      if ((gd & km) !== (m & km)) begin
        n_fail++;
        $display("FAIL rdata k=%0d adr=%h: got %h, want %h (mask %h)", k, a, gd, m, km);
      end
    end
    acks = (lat != 0) ? 1 : 0;
    for (int h = 0; h <= hold; h++) begin
      @(posedge clk); #1;
      if (ack[k]) acks++;
      if (h == 0) begin
        n_tests++;
        if (rdat[k] !== 32'd0 || irq[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL post_ack k=%0d: got dat=%h int=%b, want 0/0", k, rdat[k], irq[k]);
        end
      end
    end
    n_tests++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL ack_count k=%0d adr=%h: got %0d acks, want 1", k, a, acks);
    end
    @(negedge clk);
    cyc[k] = 1'b0; stb[k] = 1'b0;
    @(posedge clk);
    if (w && !oor && lat != 0) begin
      m = lane_mask(s);
      mdl[k][a[9:0]] = (mdl[k][a[9:0]] & ~m) | (d & m);
      kb[k][a[9:0]]  = kb[k][a[9:0]] | s;
    end
    rd = gd;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cyc = 3'($urandom); stb = 3'($urandom); we = 1'($urandom); adr = $urandom_range(0, 31);
      sel = 4'hF; wdat = $urandom;
      @(posedge clk); #1;
      n_tests++;
      if (ack !== 3'd0 || irq !== 3'd0 || rdat[0] !== 32'd0 || rdat[1] !== 32'd0 ||
          rdat[2] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got ack=%b int=%b, want all zero", i, ack, irq);
      end
    end
    @(negedge clk);
    cyc = 3'd0; stb = 3'd0; rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (ack !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_release cyc %0d: got ack=%b, want 000", i, ack);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    xfer(0, 1'b1, 32'h5, 4'hF, 32'hDEAD_BEEF, 0, rd);
    xfer(0, 1'b0, 32'h5, 4'hF, 32'd0, 0, rd);
    n_tests++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_read: got %h, want deadbeef", rd);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    xfer(0, 1'b1, 32'h5, 4'b0010, 32'h1122_3344, 0, rd);
    xfer(0, 1'b0, 32'h5, 4'hF, 32'd0, 0, rd);
    n_tests++;
    if (rd !== 32'hDEAD_33EF) begin
      n_fail++;
      $display("FAIL byte_lane: got %h, want dead33ef", rd);
    end
    xfer(0, 1'b1, 32'h5, 4'b0000, 32'hFFFF_FFFF, 0, rd);
    xfer(0, 1'b0, 32'h5, 4'hF, 32'd0, 0, rd);
    n_tests++;
    if (rd !== 32'hDEAD_33EF) begin
      n_fail++;
      $display("FAIL sel_zero: got %h, want dead33ef", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    xfer(0, 1'b1, 32'h0, 4'hF, 32'h0BAD_F00D, 0, rd);
    xfer(0, 1'b0, 32'h400, 4'hF, 32'd0, 0, rd);
    xfer(0, 1'b1, 32'h400, 4'hF, 32'h1234_5678, 0, rd);
    xfer(0, 1'b0, 32'h0, 4'hF, 32'd0, 0, rd);
    n_tests++;
    if (rd !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL oor_write_alias: got %h, want 0badf00d", rd);
    end
  endtask

  task automatic test_abort_hold();
    logic [31:0] rd;
    int          seen;
    xfer(1, 1'b1, 32'h9, 4'hF, 32'hA5A5_5A5A, 0, rd);
    @(negedge clk);
    we = 1'b1; adr = 32'h9; sel = 4'hF; wdat = 32'h0000_1111; cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stb[1] = 1'b0; cyc[1] = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack[1]) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_ack: got %0d acks, want 0", seen);
    end
    xfer(1, 1'b0, 32'h9, 4'hF, 32'd0, 0, rd);
    n_tests++;
    if (rd !== 32'hA5A5_5A5A) begin
      n_fail++;
      $display("FAIL abort_write: got %h, want a5a55a5a", rd);
    end
    xfer(1, 1'b0, 32'h9, 4'hF, 32'd0, 5, rd);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int          seen;
    xfer(1, 1'b1, 32'h7, 4'hF, 32'h7777_0007, 0, rd);
    @(negedge clk);
    we = 1'b1; adr = 32'h7; sel = 4'hF; wdat = 32'hBBBB_CCCC; cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ack[1]) seen++;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack[1]) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid_ack: got %0d acks, want 0", seen);
    end
    xfer(1, 1'b0, 32'h7, 4'hF, 32'd0, 0, rd);
    n_tests++;
    if (rd !== 32'h7777_0007) begin
      n_fail++;
      $display("FAIL reset_mid_write: got %h, want 77770007", rd);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd;
    logic [31:0] d;
    d = $urandom;
    xfer(2, 1'b1, 32'h12, 4'hF, d, 0, rd);
    xfer(2, 1'b0, 32'h12, 4'hF, 32'd0, 0, rd);
    n_tests++;
    if (rd !== d) begin
      n_fail++;
      $display("FAIL zero_wait_rd: got %h, want %h", rd, d);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] a;
    int          k;
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) a = 32'h400 + ($urandom & 32'hFFFF);
      else a = $urandom_range(0, 31);
      xfer(k, 1'($urandom), a, 4'($urandom), $urandom, $urandom_range(0, 2), rd);
    end
  endtask

  initial begin
    rst = 1'b0; cyc = 3'd0; stb = 3'd0; we = 1'b0; sel = 4'd0; adr = 32'd0; wdat = 32'd0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1024; i++) begin
        mdl[k][i] = 32'd0;
        kb[k][i]  = 4'd0;
      end
    end
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_abort_hold();
    test_reset_mid();
    test_zero_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
